// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                               |
// | Description : Fetch / load-store request bus and single-port memory bus.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              ifu_req_i;
  logic [ADDR_W-1:0] ifu_addr_i;
  logic              ifu_gnt_o;
  logic              ifu_rvalid_o;
  logic [31:0]       ifu_rdata_o;

  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [31:0]       lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [31:0]       lsu_rdata_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_en_o;
  logic              mem_wr_en_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  ifu_req_i, ifu_addr_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output ifu_req_i, ifu_addr_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-requester (IFU/LSU) arbiter for a single-port memory     |
// |               with starvation guard. MEM_ARB_RR_EN selects round-robin     |
// |               conflict policy; otherwise LSU has fixed priority.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 7
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int                 c_cnt_w    = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_max_wait = c_cnt_w'(MAX_WAIT);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_ifu_wait;
  logic [c_cnt_w-1:0] r_lsu_wait;
  logic               r_last_lsu;

  logic w_ifu_max;
  logic w_lsu_max;
  logic w_policy_lsu;
  logic w_pick_lsu;
  logic w_ifu_gnt;
  logic w_lsu_gnt;

  assign w_ifu_max = (r_ifu_wait == c_max_wait);
  assign w_lsu_max = (r_lsu_wait == c_max_wait);

`ifdef MEM_ARB_RR_EN
  assign w_policy_lsu = ~r_last_lsu;
`else
  // Last-grant history is still maintained but only the round-robin policy reads it.
  logic w_unused_last;
  assign w_unused_last = r_last_lsu;
  assign w_policy_lsu  = 1'b1;
`endif

  // A saturated waiter overrides the policy; LSU wins when both are saturated.
  assign w_pick_lsu = w_lsu_max | (~w_ifu_max & w_policy_lsu);
  assign w_lsu_gnt  = ~rst_i & bus.lsu_req_i & (~bus.ifu_req_i | w_pick_lsu);
  assign w_ifu_gnt  = ~rst_i & bus.ifu_req_i & ~w_lsu_gnt;

  assign bus.ifu_gnt_o = w_ifu_gnt;
  assign bus.lsu_gnt_o = w_lsu_gnt;

  always_comb begin
    bus.mem_rd_en_o = 1'b0;
    bus.mem_wr_en_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (w_ifu_gnt) begin
      bus.mem_rd_en_o = 1'b1;
      bus.mem_addr_o  = bus.ifu_addr_i;
    end else if (w_lsu_gnt) begin
      bus.mem_rd_en_o = ~bus.lsu_we_i;
      bus.mem_wr_en_o = bus.lsu_we_i;
      bus.mem_addr_o  = bus.lsu_addr_i;
      bus.mem_wdata_o = bus.lsu_wdata_i;
    end
  end

  assign bus.ifu_rvalid_o = (r_state == RD_IFU);
  assign bus.lsu_rvalid_o = (r_state == RD_LSU);
  assign bus.ifu_rdata_o  = bus.ifu_rvalid_o ? bus.mem_rdata_i : 32'd0;
  assign bus.lsu_rdata_o  = bus.lsu_rvalid_o ? bus.mem_rdata_i : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ifu_wait <= '0;
      r_lsu_wait <= '0;
      r_last_lsu <= 1'b0;
    end else begin
      if (w_ifu_gnt) begin
        r_state <= RD_IFU;
      end else if (w_lsu_gnt && !bus.lsu_we_i) begin
        r_state <= RD_LSU;
      end else begin
        r_state <= IDLE;
      end

      if (bus.ifu_req_i && !w_ifu_gnt) begin
        if (!w_ifu_max) r_ifu_wait <= r_ifu_wait + c_cnt_one;
      end else begin
        r_ifu_wait <= '0;
      end

      if (bus.lsu_req_i && !w_lsu_gnt) begin
        if (!w_lsu_max) r_lsu_wait <= r_lsu_wait + c_cnt_one;
      end else begin
        r_lsu_wait <= '0;
      end

      if (w_ifu_gnt) begin
        r_last_lsu <= 1'b0;
      end else if (w_lsu_gnt) begin
        r_last_lsu <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Randomised scoreboard bench for mem_arbiter.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Single-port memory with one-cycle registered read.
  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_wr_en_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_rd_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
  end

  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Read-return monitor: one cycle after each read grant the owner must see its data.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rvalid", {bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rdata_o},
              e.lsu ? {1'b0, 1'b1, 32'd0, e.data} : {1'b1, 1'b0, e.data, 32'd0});
      end else begin
        check("no_rvalid", {bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rdata_o}, '0);
      end
    end
  end

  // Requester state and reference arbitration model.
  bit                pi, pl, lwe;
  logic [ADDR_W-1:0] ia, la;
  logic [31:0]       lwd;
  int                wi, wl;
  bit                last_lsu;
  int                gh[$];

  function automatic int winner(bit ri, bit rl);
    bit policy_lsu;
`ifdef MEM_ARB_RR_EN
    policy_lsu = !last_lsu;
`else
    policy_lsu = 1'b1;
`endif
    if (ri && !rl) return 1;
    if (rl && !ri) return 2;
    if (!ri && !rl) return 0;
    if (wl >= MAX_WAIT) return 2;
    if (wi >= MAX_WAIT) return 1;
    return policy_lsu ? 2 : 1;
  endfunction

  task automatic step(input bit ni, input logic [ADDR_W-1:0] nia,
                      input bit nl, input bit nwe, input logic [ADDR_W-1:0] nla,
                      input logic [31:0] nwd);
    int          g;
    logic [95:0] expv;
    @(negedge clk);
    rst = 1'b0;
    if (!pi && ni) begin pi = 1'b1; ia = nia; end
    if (!pl && nl) begin pl = 1'b1; lwe = nwe; la = nla; lwd = nwd; end
    bus.ifu_req_i   = pi;
    bus.ifu_addr_i  = ia;
    bus.lsu_req_i   = pl;
    bus.lsu_we_i    = lwe;
    bus.lsu_addr_i  = la;
    bus.lsu_wdata_i = lwd;
    #1;
    g = winner(pi, pl);
    case (g)
      1:       expv = {1'b1, 1'b0, 1'b1, 1'b0, ia, 32'd0};
      2:       expv = {1'b0, 1'b1, !lwe, lwe, la, lwd};
      default: expv = '0;
    endcase
    check("grant", {bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_rd_en_o, bus.mem_wr_en_o,
                    bus.mem_addr_o, bus.mem_wdata_o}, expv);
    gh.push_back(bus.ifu_gnt_o ? 1 : (bus.lsu_gnt_o ? 2 : 0));
    if (g == 1) sbq.push_back('{1'b0, ref_mem[ia]});
    if (g == 2 && !lwe) sbq.push_back('{1'b1, ref_mem[la]});
    if (g == 2 && lwe) ref_mem[la] = lwd;
    wi = (pi && g != 1) ? ((wi + 1 > MAX_WAIT) ? MAX_WAIT : wi + 1) : 0;
    wl = (pl && g != 2) ? ((wl + 1 > MAX_WAIT) ? MAX_WAIT : wl + 1) : 0;
    if (g == 1) begin last_lsu = 1'b0; pi = 1'b0; end
    if (g == 2) begin last_lsu = 1'b1; pl = 1'b0; end
  endtask

  // Called just after a step's grant check: reset covers the next rising edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    sbq.delete();
    pi = 1'b0; pl = 1'b0;
    wi = 0; wl = 0; last_lsu = 1'b0;
    bus.ifu_req_i = 1'b1;
    bus.lsu_req_i = 1'b1;
    #1;
    check("reset_outputs", {bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_rd_en_o, bus.mem_wr_en_o,
                            bus.mem_addr_o, bus.mem_wdata_o, bus.ifu_rvalid_o, bus.lsu_rvalid_o}, '0);
    check("reset_rdata", {bus.ifu_rdata_o, bus.lsu_rdata_o}, '0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.ifu_req_i = 1'b0; bus.ifu_addr_i = '0;
    bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = '0; bus.lsu_wdata_i = '0;
    ia = '0; la = '0; lwe = 1'b0; lwd = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = 32'h1000_0000 + i * 32'd7919;
      ref_mem[i] = 32'h1000_0000 + i * 32'd7919;
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    do_reset();

    // Single IFU read, then LSU write and read-back, then back-to-back IFU reads.
    step(1, 10'h004, 0, 0, 0, 0);
    step(0, 0, 1, 1, 10'h010, 32'h1234_5678);
    step(0, 0, 1, 0, 10'h010, 0);
    step(1, 10'h001, 0, 0, 0, 0);
    step(1, 10'h002, 0, 0, 0, 0);
    step(1, 10'h003, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("readback_mem", mem[10'h010], 32'h1234_5678);

    // Both requesting continuously from a fresh reset.
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    base = gh.size();
    for (int k = 0; k < 16; k++)
      step(1, ADDR_W'(k + 32), 1, 0, ADDR_W'(k + 64), 0);
    for (int k = 0; k < 16; k++) begin
`ifdef MEM_ARB_RR_EN
      check("rr_pattern", gh[base + k], (k % 2 == 0) ? 2 : 1);
`else
      check("starve_pattern", gh[base + k], (k % 8 == 7) ? 1 : 2);
`endif
    end

    // Reset pulsed while an IFU read is in flight.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 10'h005, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 10'h006, 1, 0, 10'h007, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomised traffic over a small address window to exercise read-after-write.
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
           ADDR_W'($urandom_range(0, 31)), $urandom);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 SHALL have parameter MAX_WAIT, default 7, max cycles a pending requester may be refused before a forced grant.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports ifu_req_i in 1, ifu_addr_i in ADDR_W: fetch read request and word address.
REQ-006 SHALL have ports ifu_gnt_o out 1, ifu_rvalid_o out 1, ifu_rdata_o out 32: fetch grant, read-valid pulse, read data.
REQ-007 SHALL have ports lsu_req_i in 1, lsu_we_i in 1, lsu_addr_i in ADDR_W, lsu_wdata_i in 32: load/store request, write flag, word address, write data.
REQ-008 SHALL have ports lsu_gnt_o out 1, lsu_rvalid_o out 1, lsu_rdata_o out 32: load/store grant, read-valid pulse, read data.
REQ-009 SHALL have ports mem_addr_o out ADDR_W, mem_rd_en_o out 1, mem_wr_en_o out 1, mem_wdata_o out 32, mem_rdata_i in 32: single-port memory with 1-cycle registered read latency.

Function
REQ-010 SHALL issue at most one memory access per cycle; grant and issue are the same cycle (gnt combinational from req and state).
REQ-011 Requester SHALL hold req/addr/we/wdata stable until its gnt; arbiter SHALL NOT depend on inputs after the grant cycle.
REQ-012 Granted IFU: mem_rd_en_o=1, mem_wr_en_o=0, mem_addr_o=ifu_addr_i, mem_wdata_o=0.
REQ-013 Granted LSU: mem_rd_en_o=~lsu_we_i, mem_wr_en_o=lsu_we_i, mem_addr_o=lsu_addr_i, mem_wdata_o=lsu_wdata_i.
REQ-014 No grant: mem_rd_en_o=0, mem_wr_en_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-015 SHALL track the in-flight read in a state machine: IDLE, RD_IFU, RD_LSU.
REQ-016 Transitions: any state -> RD_IFU on IFU grant; -> RD_LSU on LSU read grant; -> IDLE on LSU write grant or no grant.
REQ-017 In RD_IFU, ifu_rvalid_o=1 for exactly one cycle with ifu_rdata_o=mem_rdata_i; likewise RD_LSU for lsu_*; rdata outputs SHALL be 0 when rvalid is 0.
REQ-018 Read return and a new grant in the same cycle SHALL be supported (back-to-back, one access per cycle sustained).
REQ-019 Single requester SHALL be granted in the cycle it requests.
REQ-020 Conflict resolution per REQ-029/030; the loser SHALL see gnt=0 and keep requesting.
REQ-021 SHALL keep a per-requester wait counter (saturating at MAX_WAIT), incremented each cycle req=1 and gnt=0, cleared on grant or req=0.
REQ-022 When a wait counter equals MAX_WAIT, that requester SHALL win the next conflict regardless of policy; if both at MAX_WAIT, LSU wins.
REQ-023 Writes SHALL produce no rvalid.

Reset
REQ-024 While rst_i=1: state=IDLE, wait counters=0, last-grant register=IFU, all outputs 0 including gnt.
REQ-025 Reset asserted with a read in flight SHALL discard it; no rvalid SHALL appear after reset release for that access.
REQ-026 First cycle after rst_i deasserts SHALL accept requests normally.

Configuration
REQ-027 Macro MEM_ARB_RR_EN SHALL select the conflict policy.
REQ-028 SHALL keep a last-grant register updated on every grant (used only with macro defined).
REQ-029 With MEM_ARB_RR_EN defined: on conflict, grant the requester not granted most recently (round-robin).
REQ-030 Without MEM_ARB_RR_EN: on conflict, LSU wins (fixed priority); wait-counter override (REQ-022) still applies.

Verification
REQ-031 IFU only, addr 0x004, mem_rdata_i=0xDEADBEEF next cycle -> ifu_gnt_o=1 cycle 0, ifu_rvalid_o=1 and ifu_rdata_o=0xDEADBEEF cycle 1.
REQ-032 LSU write addr 0x010 data 0x12345678 -> mem_wr_en_o=1, mem_wdata_o=0x12345678 same cycle; no rvalid next cycle.
REQ-033 Both request continuously, macro defined -> grants alternate LSU, IFU, LSU, IFU; each rvalid routed to the correct owner.
REQ-034 Both request continuously, macro undefined, MAX_WAIT=7 -> LSU granted 7 cycles, IFU forced grant in the 8th cycle, repeat.
REQ-035 IFU read granted, rst_i pulsed next cycle before rvalid -> ifu_rvalid_o stays 0, all outputs 0 during reset, state IDLE after.
REQ-036 Back-to-back IFU reads addr 1,2,3 -> one grant per cycle, rvalid on cycles 1,2,3 with matching data.
